mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
// The stage drives the request side; the memory answers with ack and read data.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store,
// stalls EX/MEM until ack, and flags misaligned or timed-out accesses.
module mem_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteIn,
  input  logic              MemtoRegIn,
  input  logic              MemWriteIn,
  input  logic [31:0]       ALUResultIn,
  input  logic [4:0]        WriteRegIn,
  input  logic [31:0]       WriteDataIn,
  mem_stage_if.master       bus,
  output logic              stall,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [31:0]       ReadDataOut,
  output logic [31:0]       ALUResultOut,
  output logic [4:0]        WriteRegOut,
  output logic              AlignErr,
  output logic              BusErr
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state;
  logic [3:0]  waitCnt;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic memOp;
  logic aligned;
  logic lastWait;

  assign memOp    = MemtoRegIn | MemWriteIn;
  assign aligned  = (ALUResultIn[1:0] == 2'b00);
  assign lastWait = (waitCnt == 4'hF);

  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

  // Hold upstream while an access is pending or about to be issued.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      unique case (state)
        S_IDLE: stall = memOp & aligned;
        S_WAIT: stall = ~bus.mem_ack & ~lastWait;
        default: stall = 1'b0;
      endcase
    end
  end

  // Access FSM, bus request registers and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      waitCnt      <= 4'd0;
      req          <= 1'b0;
      we           <= 1'b0;
      addr         <= 32'd0;
      wdata        <= 32'd0;
      RegWriteOut  <= 1'b0;
      MemtoRegOut  <= 1'b0;
      ReadDataOut  <= 32'd0;
      ALUResultOut <= 32'd0;
      WriteRegOut  <= 5'd0;
      AlignErr     <= 1'b0;
      BusErr       <= 1'b0;
    end else begin
      AlignErr <= 1'b0;
      BusErr   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            !memOp: begin
              RegWriteOut  <= RegWriteIn;
              MemtoRegOut  <= MemtoRegIn;
              ReadDataOut  <= 32'd0;
              ALUResultOut <= ALUResultIn;
              WriteRegOut  <= WriteRegIn;
            end
            memOp && !aligned: begin
              RegWriteOut  <= 1'b0;
              MemtoRegOut  <= 1'b0;
              ReadDataOut  <= 32'd0;
              ALUResultOut <= 32'd0;
              WriteRegOut  <= 5'd0;
              AlignErr     <= 1'b1;
            end
            memOp && aligned: begin
              state   <= S_WAIT;
              req     <= 1'b1;
              we      <= MemWriteIn;
              addr    <= ALUResultIn;
              wdata   <= WriteDataIn;
              waitCnt <= 4'd0;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          unique case (1'b1)
            bus.mem_ack: begin
              RegWriteOut  <= RegWriteIn;
              MemtoRegOut  <= MemtoRegIn;
              ReadDataOut  <= MemWriteIn ? 32'd0 : bus.mem_rdata;
              ALUResultOut <= ALUResultIn;
              WriteRegOut  <= WriteRegIn;
              req          <= 1'b0;
              state        <= S_IDLE;
            end
            !bus.mem_ack && lastWait: begin
              RegWriteOut  <= 1'b0;
              MemtoRegOut  <= 1'b0;
              ReadDataOut  <= 32'd0;
              ALUResultOut <= 32'd0;
              WriteRegOut  <= 5'd0;
              BusErr       <= 1'b1;
              req          <= 1'b0;
              state        <= S_IDLE;
            end
            !bus.mem_ack && !lastWait: begin
              waitCnt <= waitCnt + 4'd1;
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
